sic_mem_arbiter: RTL and testbench

Two-port arbiter placed between the SIC CPU, a second memory master (program loader / debug port), and the single-port `sic_memory`. It issues at most one memory access per cycle. Arbitration is round-robin, with an optional bounded lock for back-to-back bursts. Read data is returned to the issuing port with fixed latency, so the CPU and the loader can share one memory without changes to either.

---
 rtl/sic_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_sic_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sic_mem_arbiter.sv
// Round-robin arbiter between the SIC CPU and a second memory master in front of
// a single-port memory, with a bounded lock and fixed-latency read return.
module sic_mem_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 15,
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned MAX_HOLD      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     ext_req,
    input  logic                     cpu_lock,
    input  logic                     ext_lock,
    input  logic                     cpu_we,
    input  logic                     ext_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [ADDRESS_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    input  logic [DATA_WIDTH-1:0]    ext_wdata,
    output logic                     cpu_gnt,
    output logic                     ext_gnt,
    output logic                     cpu_rvalid,
    output logic                     ext_rvalid,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic [DATA_WIDTH-1:0]    ext_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_write_enable,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    localparam logic       PortCpu = 1'b0;
    localparam logic       PortExt = 1'b1;
    localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

    logic                  r_last;
    logic [3:0]            r_hold_cnt;
    logic                  r_s1_valid;
    logic                  r_s1_tag;
    logic                  r_s2_valid;
    logic                  r_s2_tag;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ext_rdata;

    logic                  w_both;
    logic                  w_last_lock;
    logic                  w_gnt;
    logic                  w_sel;
    logic                  w_sel_we;
    logic                  w_last_d;
    logic [3:0]            w_hold_d;

    assign w_both      = cpu_req & ext_req;
    assign w_last_lock = (r_last == PortExt) ? ext_lock : cpu_lock;

    // Grants are suppressed combinationally while reset is asserted.
    always_comb begin
        w_gnt = 1'b0;
        w_sel = PortCpu;
        if (rst) begin
            if (w_both) begin
                w_gnt = 1'b1;
                w_sel = (w_last_lock && (r_hold_cnt < MaxHold)) ? r_last : ~r_last;
            end else if (cpu_req) begin
                w_gnt = 1'b1;
                w_sel = PortCpu;
            end else if (ext_req) begin
                w_gnt = 1'b1;
                w_sel = PortExt;
            end
        end
    end

    assign cpu_gnt  = w_gnt & (w_sel == PortCpu);
    assign ext_gnt  = w_gnt & (w_sel == PortExt);
    assign w_sel_we = (w_sel == PortExt) ? ext_we : cpu_we;

    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        if (w_gnt) begin
            mem_address      = (w_sel == PortExt) ? ext_addr : cpu_addr;
            mem_write_data   = (w_sel == PortExt) ? ext_wdata : cpu_wdata;
            mem_write_enable = w_sel_we;
        end
    end

    // The hold count only tracks streaks while the other port is actually waiting.
    always_comb begin
        w_hold_d = '0;
        w_last_d = r_last;
        if (w_gnt) begin
            w_last_d = w_sel;
            if (w_both) begin
                if (w_sel == r_last) begin
                    w_hold_d = (r_hold_cnt >= MaxHold) ? MaxHold : r_hold_cnt + 4'd1;
                end else begin
                    w_hold_d = 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last     <= PortExt;
            r_hold_cnt <= '0;
        end else begin
            r_last     <= w_last_d;
            r_hold_cnt <= w_hold_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_tag    <= PortCpu;
            r_s2_valid  <= 1'b0;
            r_s2_tag    <= PortCpu;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
        end else begin
            r_s1_valid <= w_gnt & ~w_sel_we;
            r_s1_tag   <= w_sel;
            r_s2_valid <= r_s1_valid;
            r_s2_tag   <= r_s1_tag;
            if (r_s1_valid) begin
                if (r_s1_tag == PortExt) begin
                    r_ext_rdata <= mem_read_data;
                end else begin
                    r_cpu_rdata <= mem_read_data;
                end
            end
        end
    end

    assign cpu_rvalid = r_s2_valid & (r_s2_tag == PortCpu);
    assign ext_rvalid = r_s2_valid & (r_s2_tag == PortExt);
    assign cpu_rdata  = r_cpu_rdata;
    assign ext_rdata  = r_ext_rdata;

endmodule

// File: tb/tb_sic_mem_arbiter.sv
// Randomized bench for sic_mem_arbiter: two request generators, a behavioural
// memory, and a transaction-level reference model of grants and read returns.
module tb_sic_mem_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 24;
    localparam int unsigned MH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0, ext_req = 1'b0, cpu_lock = 1'b0, ext_lock = 1'b0;
    logic          cpu_we = 1'b0, ext_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, ext_wdata = '0;
    logic          cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid;
    logic [DW-1:0] cpu_rdata, ext_rdata;
    logic [AW-1:0] mem_address;
    logic          mem_write_enable;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;

    always #5 clk = ~clk;

    sic_mem_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .MAX_HOLD     (MH)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req         (cpu_req),
        .ext_req         (ext_req),
        .cpu_lock        (cpu_lock),
        .ext_lock        (ext_lock),
        .cpu_we          (cpu_we),
        .ext_we          (ext_we),
        .cpu_addr        (cpu_addr),
        .ext_addr        (ext_addr),
        .cpu_wdata       (cpu_wdata),
        .ext_wdata       (ext_wdata),
        .cpu_gnt         (cpu_gnt),
        .ext_gnt         (ext_gnt),
        .cpu_rvalid      (cpu_rvalid),
        .ext_rvalid      (ext_rvalid),
        .cpu_rdata       (cpu_rdata),
        .ext_rdata       (ext_rdata),
        .mem_address     (mem_address),
        .mem_write_enable(mem_write_enable),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data)
    );

    // Single-port memory: write commits at the edge, read data one cycle later.
    logic [DW-1:0] mem [0:31];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[4:0]] <= mem_write_data;
        mem_read_data <= mem[mem_address[4:0]];
    end

    typedef struct {
        int          port;
        int          due;
        logic [DW-1:0] data;
    } rd_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            m_last = 1;
    int            m_hold = 0;
    logic [DW-1:0] ref_mem [0:31];
    logic [DW-1:0] exp_rdata [2];
    rd_t           rd_q[$];

    logic          pend [2];
    logic          wr [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd [2];
    logic          lk [2];
    int            p_new = 0;
    bit            lock_rand = 1'b1;
    int            run_port = -1, run_len = 0, max_run [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        cpu_req = pend[0]; cpu_we = wr[0]; cpu_addr = addr[0]; cpu_wdata = wd[0]; cpu_lock = lk[0];
        ext_req = pend[1]; ext_we = wr[1]; ext_addr = addr[1]; ext_wdata = wd[1]; ext_lock = lk[1];
    endtask

    task automatic set_req(input int p, input logic w, input int a, input logic [DW-1:0] d);
        pend[p] = 1'b1;
        wr[p]   = w;
        addr[p] = AW'(a);
        wd[p]   = d;
    endtask

    task automatic do_cycle();
        logic          exp_rv [2];
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_we;
        bit            both;
        int            g;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (!pend[p] && ($urandom_range(99) < p_new))
                set_req(p, 1'($urandom_range(1)), int'($urandom_range(31)), DW'($urandom));
            if (lock_rand) lk[p] = 1'($urandom_range(1));
        end
        drive();
        #1;
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        while (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            exp_rv[rd_q[0].port]    = 1'b1;
            exp_rdata[rd_q[0].port] = rd_q[0].data;
            void'(rd_q.pop_front());
        end
        check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_rv[0]));
        check_eq("ext_rvalid", 32'(ext_rvalid), 32'(exp_rv[1]));
        check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata[0]));
        check_eq("ext_rdata", 32'(ext_rdata), 32'(exp_rdata[1]));

        both = pend[0] && pend[1];
        g = -1;
        if (both) g = (lk[m_last] && m_hold < int'(MH)) ? m_last : 1 - m_last;
        else if (pend[0]) g = 0;
        else if (pend[1]) g = 1;

        e_addr = '0; e_wdata = '0; e_we = 1'b0;
        if (g >= 0) begin
            e_addr = addr[g]; e_wdata = wd[g]; e_we = wr[g];
        end
        check_eq("cpu_gnt", 32'(cpu_gnt), 32'(g == 0));
        check_eq("ext_gnt", 32'(ext_gnt), 32'(g == 1));
        check_eq("mem_address", 32'(mem_address), 32'(e_addr));
        check_eq("mem_write_enable", 32'(mem_write_enable), 32'(e_we));
        check_eq("mem_write_data", 32'(mem_write_data), 32'(e_wdata));

        if (cpu_gnt || ext_gnt) begin
            if (run_port == int'(ext_gnt)) run_len++;
            else run_len = 1;
            run_port = int'(ext_gnt);
            if (run_len > max_run[run_port]) max_run[run_port] = run_len;
        end else begin
            run_port = -1;
        end

        if (g >= 0) begin
            if (both) m_hold = (g != m_last) ? 1 : ((m_hold < int'(MH)) ? m_hold + 1 : int'(MH));
            else m_hold = 0;
            m_last = g;
            if (wr[g]) ref_mem[addr[g][4:0]] = wd[g];
            else rd_q.push_back('{port: g, due: cyc + 2, data: ref_mem[addr[g][4:0]]});
            pend[g] = 1'b0;
        end else begin
            m_hold = 0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive();
        #1;
        check_eq("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check_eq("rst_ext_gnt", 32'(ext_gnt), 32'd0);
        check_eq("rst_mem_we", 32'(mem_write_enable), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_address), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_write_data), 32'd0);
        check_eq("rst_rvalid", 32'({cpu_rvalid, ext_rvalid}), 32'd0);
        check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check_eq("rst_ext_rdata", 32'(ext_rdata), 32'd0);
        m_last = 1;
        m_hold = 0;
        rd_q.delete();
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; wd[p] = '0; lk[p] = 1'b0;
            exp_rdata[p] = '0; max_run[p] = 0;
        end
        // Both ports request writes while reset is held.
        set_req(0, 1'b1, 3, 24'h0a0a0a);
        set_req(1, 1'b1, 4, 24'h0b0b0b);
        do_reset();
        idle(2);

        for (int a = 0; a < 32; a++) begin
            set_req(0, 1'b1, a, DW'($urandom));
            do_cycle();
        end

        set_req(0, 1'b1, 16, 24'h123456);
        do_cycle();
        set_req(0, 1'b0, 16, '0);
        do_cycle();
        idle(3);
        check_eq("wr_rd_cpu_rdata", 32'(cpu_rdata), 32'h123456);

        lock_rand = 1'b0;
        lk[0] = 1'b0;
        lk[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!pend[0]) set_req(0, 1'b0, 1, '0);
            if (!pend[1]) set_req(1, 1'b0, 2, '0);
            do_cycle();
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle(3);

        // Ext locked, cpu never locks: longest ext streak must equal MAX_HOLD.
        lk[1] = 1'b1;
        p_new = 100;
        max_run[0] = 0;
        max_run[1] = 0;
        run_port = -1;
        idle(30);
        check_eq("lock_ext_run", 32'(max_run[1]), 32'(MH));
        check_eq("lock_cpu_run", 32'(max_run[0]), 32'd1);
        p_new = 0;
        idle(3);

        lk[1] = 1'b0;
        set_req(0, 1'b0, 5, '0);
        do_cycle();
        set_req(1, 1'b1, 6, 24'h654321);
        set_req(0, 1'b0, 6, '0);
        do_cycle();
        do_cycle();
        idle(3);
        check_eq("contend_cpu_rdata", 32'(cpu_rdata), 32'h654321);

        set_req(0, 1'b0, 16, '0);
        do_cycle();
        do_reset();
        idle(4);
        check_eq("midread_cpu_rdata", 32'(cpu_rdata), 32'd0);

        lock_rand = 1'b1;
        p_new = 50;
        idle(300);
        p_new = 0;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
